// File: rtl/dmem_mmio_responder_pkg.sv
// Shared definitions for the data-memory MMIO responder: register map,
// STATUS bit layout and serializer states.
package dmem_mmio_pkg;

    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CYCLE  = 3'd2;
    localparam logic [2:0] REG_GPIO   = 3'd3;
    localparam logic [2:0] REG_BAUD   = 3'd4;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Data-memory bus as seen by the SRAMs: active-low enables, word address,
// store data, plus the responder's read data and bus-ownership flag.
interface dmem_mmio_responder_if;
    logic        ce_n;
    logic [3:0]  oe_n;
    logic [3:0]  we_n;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rd_drive;

    modport master (output ce_n, oe_n, we_n, addr, wdata, input rdata, rd_drive);
    modport slave  (input ce_n, oe_n, we_n, addr, wdata, output rdata, rd_drive);
endinterface

// File: rtl/dmem_mmio_responder_uart_tx.sv
// 8N1 transmitter: byte FIFO feeding a START/DATA/STOP serializer whose
// bit period (baud_div+1 cycles) is re-sampled at the start of every bit.
module mmio_uart_tx
    import dmem_mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic [15:0]   baud_div,
    input  logic          overflow_clr,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          tx
);

    tx_state_e       state_q, state_d;
    logic [15:0]     bit_cnt_q, bit_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic            pop, push_ok, bit_done;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign bit_done = (bit_cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        pop       = 1'b0;
        tx        = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shreg_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = baud_div;
                    state_d   = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_done) begin
                    bit_idx_d = '0;
                    bit_cnt_d = baud_div;
                    state_d   = DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            DATA: begin
                tx = shreg_q[bit_idx_q];
                if (bit_done) begin
                    bit_cnt_d = baud_div;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    // Chain straight into the next frame so back-to-back bytes have no idle gap.
                    if (!empty) begin
                        pop       = 1'b1;
                        shreg_d   = mem_q[rd_ptr_q];
                        bit_cnt_d = baud_div;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        push_ok  = push && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop);

        overflow_d = overflow_clr ? 1'b0 : overflow_q;
        if (push && !push_ok) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// MMIO register window on the data-memory bus: address decode, byte-lane
// writes, CYCLE/GPIO/BAUDDIV registers, read mux and the UART transmitter.
module dmem_mmio_responder
    import dmem_mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [14:0] BASE       = 15'h7FF0,
    parameter logic [15:0] BAUD_RESET = 16'd16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_mmio_responder_if.slave  bus,
    output logic [31:0]           gpio_out,
    output logic                  tx
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [14:0] BASE_LAST = BASE + 15'd4;

    logic [31:0]   cycle_q, cycle_d, gpio_q, gpio_d;
    logic [15:0]   baud_q, baud_d;
    logic          hit, push, ovf_clr, full, empty, overflow;
    logic [2:0]    sel;
    logic [3:0]    wr_lane;
    logic [CW-1:0] count;

    assign hit     = !bus.ce_n && (bus.addr >= BASE) && (bus.addr <= BASE_LAST);
    assign sel     = 3'(bus.addr - BASE);
    assign wr_lane = {4{hit}} & ~bus.we_n;
    assign push    = wr_lane[0] && (sel == REG_TXDATA);
    assign ovf_clr = wr_lane[0] && (sel == REG_STATUS) && bus.wdata[ST_OVF];

    always_comb begin
        // Unwritten CYCLE bytes still advance, so a partial write never stalls the count.
        cycle_d = cycle_q + 32'd1;
        gpio_d  = gpio_q;
        baud_d  = baud_q;
        for (int i = 0; i < 4; i++) begin
            if (wr_lane[i] && sel == REG_CYCLE) cycle_d[8*i +: 8] = bus.wdata[8*i +: 8];
            if (wr_lane[i] && sel == REG_GPIO)  gpio_d[8*i +: 8]  = bus.wdata[8*i +: 8];
        end
        for (int i = 0; i < 2; i++) begin
            if (wr_lane[i] && sel == REG_BAUD) baud_d[8*i +: 8] = bus.wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            gpio_q  <= '0;
            baud_q  <= BAUD_RESET;
        end else begin
            cycle_q <= cycle_d;
            gpio_q  <= gpio_d;
            baud_q  <= baud_d;
        end
    end

    assign gpio_out     = gpio_q;
    assign bus.rd_drive = hit && (bus.we_n == 4'hF) && (bus.oe_n != 4'hF);

    always_comb begin
        bus.rdata = '0;
        if (bus.rd_drive) begin
            unique case (sel)
                REG_STATUS: begin
                    bus.rdata[ST_CNT_LSB +: 4] = 4'(count);
                    bus.rdata[ST_OVF]          = overflow;
                    bus.rdata[ST_EMPTY]        = empty;
                    bus.rdata[ST_FULL]         = full;
                end
                REG_CYCLE: bus.rdata = cycle_q;
                REG_GPIO:  bus.rdata = gpio_q;
                REG_BAUD:  bus.rdata = {16'b0, baud_q};
                default:   bus.rdata = '0;
            endcase
        end
    end

    mmio_uart_tx #(.FIFO_DEPTH(FIFO_DEPTH)) u_uart_tx (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .push_data    (bus.wdata[7:0]),
        .baud_div     (baud_q),
        .overflow_clr (ovf_clr),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .tx           (tx)
    );

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: register access, decode limits,
// UART framing, FIFO overflow, CYCLE byte writes and asynchronous reset.
module tb_dmem_mmio_responder;

    localparam logic [14:0] BASE = 15'h7FF0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] gpio_out;
    logic        tx;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    dmem_mmio_responder_if bus();

    dmem_mmio_responder #(.FIFO_DEPTH(8), .BASE(BASE), .BAUD_RESET(16'd16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .gpio_out (gpio_out),
        .tx       (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.ce_n = 1'b1;
        bus.oe_n = 4'hF;
        bus.we_n = 4'hF;
    endtask

    task automatic wr(input logic [14:0] a, input logic [31:0] d, input logic [3:0] we);
        @(negedge clk);
        bus.ce_n = 1'b0; bus.addr = a; bus.wdata = d; bus.we_n = we; bus.oe_n = 4'hF;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic rd(input logic [14:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        bus.ce_n = 1'b0; bus.addr = a; bus.we_n = 4'hF; bus.oe_n = 4'h0;
        #1;
        d = bus.rdata;
        v = bus.rd_drive;
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        logic [31:0] d;
        logic        v;
        logic [7:0]  pat;
        int          m, bitn;
        logic        exp_tx;

        idle();
        bus.addr = '0;
        bus.wdata = '0;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_drive", 32'(bus.rd_drive), 32'd0);
        repeat (2) @(posedge clk);

        // Release reset and read CYCLE before the first active edge.
        @(negedge clk);
        rst_n = 1'b1;
        bus.ce_n = 1'b0; bus.addr = BASE + 15'd2; bus.oe_n = 4'h0; bus.we_n = 4'hF;
        #1;
        chk("cycle_first", bus.rdata, 32'h0);
        chk("cycle_first_drv", 32'(bus.rd_drive), 32'd1);
        @(posedge clk); #1;
        idle();

        rd(BASE + 15'd1, d, v); chk("status_rst", d, 32'h02);
        rd(BASE + 15'd4, d, v); chk("baud_rst", d, 32'd16);

        wr(BASE + 15'd3, 32'hAABBCCDD, 4'b1010);
        chk("gpio_lanes", gpio_out, 32'h00BB00DD);
        rd(BASE + 15'd3, d, v);
        chk("gpio_rd", d, 32'h00BB00DD);
        chk("gpio_rd_drv", 32'(v), 32'd1);

        // Decode limits: just past the window, just below it, and chip disabled.
        wr(BASE + 15'd5, 32'hFFFFFFFF, 4'h0);
        chk("oow_hi_wr", gpio_out, 32'h00BB00DD);
        rd(BASE + 15'd5, d, v);
        chk("oow_hi_drv", 32'(v), 32'd0);
        chk("oow_hi_data", d, 32'h0);
        wr(BASE - 15'd1, 32'h11111111, 4'h0);
        chk("oow_lo_wr", gpio_out, 32'h00BB00DD);
        @(negedge clk);
        bus.ce_n = 1'b1; bus.addr = BASE + 15'd3; bus.oe_n = 4'h0; bus.we_n = 4'h0;
        bus.wdata = 32'h12345678;
        #1;
        chk("ce_off_drv", 32'(bus.rd_drive), 32'd0);
        chk("ce_off_data", bus.rdata, 32'h0);
        @(posedge clk); #1;
        idle();
        chk("ce_off_wr", gpio_out, 32'h00BB00DD);

        wr(BASE + 15'd4, 32'hFFFF0003, 4'h0);
        rd(BASE + 15'd4, d, v); chk("baud_wr", d, 32'h3);

        // Single frame at 4 cycles per bit: pop one edge after the push.
        wr(BASE, 32'h00000055, 4'b1110);
        pat = 8'h55;
        for (int k = 0; k <= 40; k++) begin
            @(posedge clk); #1;
            bitn = k / 4;
            if (bitn == 0) exp_tx = 1'b0;
            else if (bitn <= 8) exp_tx = pat[bitn-1];
            else exp_tx = 1'b1;
            chk($sformatf("frame_k%0d", k), 32'(tx), 32'(exp_tx));
        end

        // Ten back-to-back pushes: one is popped, eight fill the FIFO, the tenth overflows.
        for (int i = 0; i < 10; i++) begin
            wr(BASE, 32'(8'hA0 + i), 4'b1110);
            if (i == 0) m = cyc;
        end
        rd(BASE + 15'd1, d, v); chk("status_full_ovf", d, 32'h85);
        rd(BASE, d, v); chk("txdata_rd", d, 32'h0);
        wr(BASE + 15'd1, 32'h4, 4'b1110);
        rd(BASE + 15'd1, d, v); chk("status_ovf_clr", d, 32'h81);

        while (cyc < m + 40) begin
            @(posedge clk); #1;
        end
        chk("stop_bit", 32'(tx), 32'd1);
        @(posedge clk); #1;
        chk("b2b_start", 32'(tx), 32'd0);
        rd(BASE + 15'd1, d, v); chk("status_after_pop", d, 32'h70);

        // Asynchronous reset mid-frame.
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", 32'(tx), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        rd(BASE + 15'd1, d, v); chk("rst_mid_fifo", d, 32'h02);
        chk("rst_mid_gpio", gpio_out, 32'h0);

        wr(BASE + 15'd2, 32'h000000FF, 4'h0);
        wr(BASE + 15'd2, 32'h12000000, 4'b0111);
        rd(BASE + 15'd2, d, v); chk("cycle_lane3", d, 32'h12000100);
        rd(BASE + 15'd2, d, v); chk("cycle_run", d, 32'h12000101);
        wr(BASE + 15'd2, 32'hFFFFFFFF, 4'h0);
        rd(BASE + 15'd2, d, v); chk("cycle_max", d, 32'hFFFFFFFF);
        rd(BASE + 15'd2, d, v); chk("cycle_wrap", d, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
